// File: rtl/keccak_pkg.sv
// keccak_pkg: shared lane width, lane count and lane-index helpers for Keccak-f[800]
package keccak_pkg;
  localparam int LANE_W = 32;
  localparam int NLANES = 25;
  typedef logic [4:0] idx_t;
  localparam idx_t LAST_IDX = 5'd24;
  function automatic idx_t lane_x(idx_t i);
    return i % 5'd5;
  endfunction
  function automatic idx_t lane_y(idx_t i);
    return i / 5'd5;
  endfunction
  function automatic idx_t lane_idx(idx_t x, idx_t y);
    return x + 5'd5 * y;
  endfunction
  // output lane (x,y) is fed from input lane (y, (2x+3y) mod 5)
  function automatic idx_t pi_inv_src(idx_t o);
    return lane_idx(lane_y(o), (5'd2 * lane_x(o) + 5'd3 * lane_y(o)) % 5'd5);
  endfunction
endpackage

// File: rtl/keccak_pi_inv_idx.sv
// keccak_pi_inv_idx: maps an output lane index to its inverse-pi source lane index
module keccak_pi_inv_idx
  import keccak_pkg::*;
(
  input  idx_t dst,
  output idx_t src
);
  assign src = pi_inv_src(dst);
endmodule

// File: rtl/keccak_pi_inv_stream.sv
// keccak_pi_inv_stream: streaming inverse Keccak pi over ping-pong 25-lane banks
module keccak_pi_inv_stream
  import keccak_pkg::NLANES, keccak_pkg::idx_t, keccak_pkg::LAST_IDX;
#(
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_lane,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              err
);
  logic [LANE_W-1:0] bank [2][NLANES];
  logic [1:0] full;
  logic wsel, rsel, wr, rd;
  idx_t wcnt, rcnt, src;
  assign in_ready  = ~full[wsel];
  assign wr        = in_valid & in_ready;
  assign out_valid = full[rsel];
  assign rd        = out_valid & out_ready;
  assign out_lane  = bank[rsel][src];
  assign out_last  = out_valid & (rcnt == LAST_IDX);
  keccak_pi_inv_idx u_idx (
    .dst(rcnt),
    .src(src)
  );
  // lane storage; contents survive reset since the FULL flags gate their use
  always_ff @(posedge clk) begin
    if (wr) bank[wsel][wcnt] <= in_lane;
  end
  // write/read counters, bank pointers, FULL flags and sticky framing error
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (wr) begin
        wcnt <= (wcnt == LAST_IDX) ? '0 : wcnt + 5'd1;
        if (wcnt == LAST_IDX) begin
          full[wsel] <= 1'b1;
          wsel       <= ~wsel;
        end
        if (in_last != (wcnt == LAST_IDX)) err <= 1'b1;
      end
      if (rd) begin
        rcnt <= (rcnt == LAST_IDX) ? '0 : rcnt + 5'd1;
        if (rcnt == LAST_IDX) begin
          full[rsel] <= 1'b0;
          rsel       <= ~rsel;
        end
      end
    end
  end
endmodule

// File: tb/tb_keccak_pi_inv_stream.sv
// tb_keccak_pi_inv_stream: directed and random checks of the inverse-pi lane stream
module tb_keccak_pi_inv_stream;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [31:0] in_lane = 0, out_lane;
  logic out_valid, out_ready = 0, out_last, err;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_q[$], part[$], in_log[$], out_log[$];
  int out_cyc[$];
  logic merr = 0, rand_ready = 0;
  localparam int exp_seq[25] = '{0,10,20,5,15,16,1,11,21,6,7,17,2,12,22,23,8,18,3,13,14,24,9,19,4};

  keccak_pi_inv_stream #(.LANE_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference model: each completed input state is scattered through forward pi
  always @(negedge clk) begin
    logic [31:0] st[25];
    cyc++;
    if (rst) begin
      exp_q.delete();
      part.delete();
      merr = 0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() + 24) / 25 < 2});
      chk("err", {31'd0, err}, {31'd0, merr});
      if (exp_q.size() > 0) begin
        chk("out_lane", out_lane, exp_q[0]);
        chk("out_last", {31'd0, out_last}, {31'd0, exp_q.size() % 25 == 1});
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        out_log.push_back(out_lane);
        out_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_last != (part.size() == 24)) merr = 1;
        part.push_back(in_lane);
        in_log.push_back(in_lane);
        if (part.size() == 25) begin
          for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
              st[(x + 3 * y) % 5 + 5 * x] = part[x + 5 * y];
          for (int i = 0; i < 25; i++) exp_q.push_back(st[i]);
          part.delete();
        end
      end
    end
  end

  // randomised downstream backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom % 4) != 0;
  end

  task automatic send(input logic [31:0] d, input logic l, output int stalls);
    bit done = 0;
    in_valid = 1;
    in_lane = d;
    in_last = l;
    stalls = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (stalls > 500) begin
        chk("send_timeout", 32'(stalls), 0);
        done = 1;
      end else stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask

  task automatic send_state(input int s, input int last_at, output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < 25; i++) begin
      send(32'(s * 256 + i), i == last_at, st);
      stalls += st;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    in_log.delete();
    out_log.delete();
    out_cyc.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_err", {31'd0, err}, 0);

    // lanes valued by their index give the inverse-pi index sequence
    clear_logs();
    out_ready = 1;
    for (int i = 0; i < 25; i++) send(32'(i), i == 24, st);
    drain();
    chk("seq_count", 32'(out_log.size()), 25);
    for (int i = 0; i < 25 && i < out_log.size(); i++) chk("seq_lane", out_log[i], 32'(exp_seq[i]));

    // four back-to-back states with both sides always ready
    clear_logs();
    tot = 0;
    for (int s = 1; s <= 4; s++) begin
      send_state(s, 24, st);
      tot += st;
    end
    drain();
    chk("b2b_stalls", 32'(tot), 0);
    chk("b2b_count", 32'(out_log.size()), 100);
    if (out_log.size() == 100) chk("b2b_span", 32'(out_cyc[99] - out_cyc[0]), 99);

    // downstream blocked: two banks fill, third state waits
    clear_logs();
    out_ready = 0;
    for (int s = 5; s <= 6; s++) send_state(s, 24, st);
    in_valid = 1;
    in_lane = 32'(7 * 256);
    in_last = 0;
    repeat (5) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 0);
    end
    chk("full_accepted", 32'(in_log.size()), 50);
    chk("full_no_output", 32'(out_log.size()), 0);
    @(posedge clk);
    #1 out_ready = 1;
    send_state(7, 24, st);
    drain();
    chk("full_count", 32'(out_log.size()), 75);

    // premature in_last raises the sticky error
    for (int i = 0; i < 25; i++) begin
      send(32'(8 * 256 + i), i == 10, st);
      if (i == 9) chk("err_before", {31'd0, err}, 0);
      if (i == 10) chk("err_after", {31'd0, err}, 1);
    end
    drain();
    chk("err_sticky", {31'd0, err}, 1);

    // reset mid-state discards the partial state
    for (int i = 0; i < 12; i++) send(32'(9 * 256 + i), 0, st);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midrst_err", {31'd0, err}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    repeat (30) begin
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    clear_logs();
    send_state(10, 24, st);
    drain();
    chk("midrst_count", 32'(out_log.size()), 25);

    // random gaps on both sides, checked against forward pi
    clear_logs();
    rand_ready = 1;
    for (int s = 0; s < 1000; s++)
      for (int i = 0; i < 25; i++) begin
        while ($urandom % 4 == 0) begin
          @(posedge clk);
          #1;
        end
        send($urandom, i == 24, st);
      end
    drain();
    rand_ready = 0;
    out_ready = 1;
    chk("rand_count", 32'(out_log.size()), 25000);
    if (out_log.size() == 25000 && in_log.size() == 25000) begin
      tot = 0;
      for (int s = 0; s < 1000; s++)
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            if (out_log[s * 25 + (x + 3 * y) % 5 + 5 * x] !== in_log[s * 25 + x + 5 * y]) tot++;
      chk("rand_pi_mismatches", 32'(tot), 0);
    end
    chk("rand_err", {31'd0, err}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
